// File: rtl/param_multicycle_alu.sv
// param_multicycle_alu: WIDTH-bit ALU with a registered result, iterative
// unsigned multiply/divide and valid/ready handshakes on both sides.
//
// state | meaning
// IDLE  | waiting for an operation; result registers hold the last result
// BUSY  | multiply/divide in progress, one operand bit per cycle
// DONE  | result formed from latched operands/accumulators, loads this edge
module param_multicycle_alu #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inValid,
  output logic             inReady,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  input  logic [2:0]       Signal,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] dataOut,
  output logic [WIDTH-1:0] dataOutHi,
  output logic             zero,
  output logic             overflow,
  output logic             divByZero
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_t;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_MULU = 3'b011;
  localparam logic [2:0] OP_DIVU = 3'b100;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_SLT  = 3'b111;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] data_out_q, data_out_d, data_out_hi_q, data_out_hi_d;
  logic             zero_q, zero_d, ovf_q, ovf_d, dbz_q, dbz_d;

  logic             accept;
  logic [WIDTH:0]   mul_sum, div_rem_sh, div_trial;
  logic [WIDTH-1:0] add_res, sub_res, res_lo, res_hi;
  logic             res_ovf, res_dbz;

  assign inReady   = (state_q == S_IDLE) && (!out_valid_q || outReady);
  assign accept    = inValid && inReady;
  assign outValid  = out_valid_q;
  assign dataOut   = data_out_q;
  assign dataOutHi = data_out_hi_q;
  assign zero      = zero_q;
  assign overflow  = ovf_q;
  assign divByZero = dbz_q;

  // One shift-add / restoring-divide step, plus the final result selection
  always_comb begin
    mul_sum    = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, a_q} : '0);
    div_rem_sh = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_trial  = div_rem_sh - {1'b0, b_q};
    add_res    = a_q + b_q;
    sub_res    = a_q - b_q;
    res_lo     = '0;
    res_hi     = '0;
    res_ovf    = 1'b0;
    res_dbz    = 1'b0;
    case (op_q)
      OP_AND: res_lo = a_q & b_q;
      OP_OR:  res_lo = a_q | b_q;
      OP_ADD: begin
        res_lo  = add_res;
        res_ovf = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_res[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        res_lo  = sub_res;
        res_ovf = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sub_res[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SLT: res_lo = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      OP_MULU: begin
        res_lo = acc_lo_q;
        res_hi = acc_hi_q;
      end
      OP_DIVU: begin
        if (b_q == '0) begin
          res_lo  = '1;
          res_hi  = a_q;
          res_dbz = 1'b1;
        end else begin
          res_lo = acc_lo_q;
          res_hi = acc_hi_q;
        end
      end
      default: ;
    endcase
  end

  // Next-state: acceptance, iteration, result load and output handshake
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    op_d          = op_q;
    a_d           = a_q;
    b_d           = b_q;
    acc_hi_d      = acc_hi_q;
    acc_lo_d      = acc_lo_q;
    out_valid_d   = out_valid_q && !outReady;
    data_out_d    = data_out_q;
    data_out_hi_d = data_out_hi_q;
    zero_d        = zero_q;
    ovf_d         = ovf_q;
    dbz_d         = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d     = Signal;
          a_d      = dataA;
          b_d      = dataB;
          acc_hi_d = '0;
          cnt_d    = '0;
          if (Signal == OP_MULU) begin
            acc_lo_d = dataB;
            state_d  = S_BUSY;
          end else if (Signal == OP_DIVU && dataB != '0) begin
            acc_lo_d = dataA;
            state_d  = S_BUSY;
          end else begin
            acc_lo_d = '0;
            state_d  = S_DONE;
          end
        end
      end
      S_BUSY: begin
        if (op_q == OP_MULU) begin
          {acc_hi_d, acc_lo_d} = {mul_sum, acc_lo_q[WIDTH-1:1]};
        end else if (!div_trial[WIDTH]) begin
          acc_hi_d = div_trial[WIDTH-1:0];
          acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_hi_d = div_rem_sh[WIDTH-1:0];
          acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) state_d = S_DONE;
      end
      S_DONE: begin
        state_d       = S_IDLE;
        cnt_d         = '0;
        out_valid_d   = 1'b1;
        data_out_d    = res_lo;
        data_out_hi_d = res_hi;
        zero_d        = (res_lo == '0);
        ovf_d         = res_ovf;
        dbz_d         = res_dbz;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, operand, accumulator and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      op_q          <= '0;
      a_q           <= '0;
      b_q           <= '0;
      acc_hi_q      <= '0;
      acc_lo_q      <= '0;
      out_valid_q   <= 1'b0;
      data_out_q    <= '0;
      data_out_hi_q <= '0;
      zero_q        <= 1'b0;
      ovf_q         <= 1'b0;
      dbz_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      op_q          <= op_d;
      a_q           <= a_d;
      b_q           <= b_d;
      acc_hi_q      <= acc_hi_d;
      acc_lo_q      <= acc_lo_d;
      out_valid_q   <= out_valid_d;
      data_out_q    <= data_out_d;
      data_out_hi_q <= data_out_hi_d;
      zero_q        <= zero_d;
      ovf_q         <= ovf_d;
      dbz_q         <= dbz_d;
    end
  end

endmodule

// File: tb/tb_param_multicycle_alu.sv
// Bench for param_multicycle_alu: scoreboard of expected results fed by the
// stimulus process, drained by an independent output monitor.
module tb_param_multicycle_alu;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          inValid, inReady, outValid, outReady;
  logic [W-1:0]  dataA, dataB, dataOut, dataOutHi;
  logic [2:0]    Signal;
  logic          zero, overflow, divByZero;

  logic          v8_in, r8_in, v8_out, r8_out, z8, o8, d8;
  logic [7:0]    a8, b8, lo8, hi8;
  logic [2:0]    s8;

  param_multicycle_alu #(.WIDTH(W)) u_dut (
    .clk(clk), .rst_n(rst_n), .inValid(inValid), .inReady(inReady),
    .dataA(dataA), .dataB(dataB), .Signal(Signal), .outValid(outValid),
    .outReady(outReady), .dataOut(dataOut), .dataOutHi(dataOutHi),
    .zero(zero), .overflow(overflow), .divByZero(divByZero)
  );

  param_multicycle_alu #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .inValid(v8_in), .inReady(r8_in),
    .dataA(a8), .dataB(b8), .Signal(s8), .outValid(v8_out),
    .outReady(r8_out), .dataOut(lo8), .dataOutHi(hi8),
    .zero(z8), .overflow(o8), .divByZero(d8)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         z;
    logic         ovf;
    logic         dbz;
    int           arrive;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model straight from the operation definitions
  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    longint sa, sb, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.lo = '0; e.hi = '0; e.ovf = 1'b0; e.dbz = 1'b0; e.arrive = 0;
    case (op)
      3'b000: e.lo = a & b;
      3'b001: e.lo = a | b;
      3'b010: begin
        r = sa + sb;
        e.lo = r[W-1:0];
        e.ovf = (r != longint'($signed(e.lo)));
      end
      3'b110: begin
        r = sa - sb;
        e.lo = r[W-1:0];
        e.ovf = (r != longint'($signed(e.lo)));
      end
      3'b111: e.lo = (sa < sb) ? 1 : 0;
      3'b011: begin
        p = {32'b0, a} * {32'b0, b};
        e.lo = p[31:0];
        e.hi = p[63:32];
      end
      3'b100: begin
        if (b == 0) begin
          e.lo = '1; e.hi = a; e.dbz = 1'b1;
        end else begin
          e.lo = a / b; e.hi = a % b;
        end
      end
      default: ;
    endcase
    e.z = (e.lo == 0);
    return e;
  endfunction

  function automatic int lat_of(input logic [2:0] op, input logic [W-1:0] b);
    return (op == 3'b011 || (op == 3'b100 && b != 0)) ? W + 1 : 1;
  endfunction

  function automatic logic [W-1:0] rnd_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return W'($urandom_range(0, 255));
      default: return $urandom();
    endcase
  endfunction

  // Present one operation, wait (bounded) for acceptance, push its expectation
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit rand_ready);
    exp_t e;
    int waitc = 0;
    @(negedge clk);
    inValid = 1'b1; Signal = op; dataA = a; dataB = b;
    if (rand_ready) outReady = 1'($urandom_range(0, 1));
    #1;
    while (!inReady && waitc < 300) begin
      @(negedge clk);
      if (rand_ready) outReady = 1'($urandom_range(0, 1));
      #1;
      waitc++;
    end
    if (!inReady) begin
      chk("accept_timeout", 64'(inReady), 64'd1);
      inValid = 1'b0;
    end else begin
      e = model(op, a, b);
      e.arrive = cyc + 1 + lat_of(op, b);
      q.push_back(e);
      @(posedge clk);
      #1;
      inValid = 1'b0;
      dataA = $urandom(); dataB = $urandom(); Signal = 3'($urandom_range(0, 7));
    end
  endtask

  task automatic drain();
    int n = 0;
    outReady = 1'b1;
    while ((q.size() != 0 || outValid) && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 200) chk("drain_timeout", 64'(q.size()), 64'd0);
  endtask

  // Monitor: compare each newly presented result, and its stability while held
  initial begin : monitor
    exp_t cur;
    bit prev_v = 1'b0;
    bit have_exp = 1'b0;
    forever begin
      @(negedge clk);
      #3;
      if (!rst_n) begin
        prev_v = 1'b0;
      end else if (outValid) begin
        if (!prev_v) begin
          if (q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_result actual=%h required=none", dataOut);
            have_exp = 1'b0;
          end else begin
            cur = q.pop_front();
            have_exp = 1'b1;
            chk("latency", 64'(cyc), 64'(cur.arrive));
            chk("dataOut", 64'(dataOut), 64'(cur.lo));
            chk("dataOutHi", 64'(dataOutHi), 64'(cur.hi));
            chk("flags_z_ovf_dbz", 64'({zero, overflow, divByZero}), 64'({cur.z, cur.ovf, cur.dbz}));
          end
        end else if (have_exp) begin
          chk("hold_data", {dataOut, dataOutHi}, {cur.lo, cur.hi});
          chk("hold_flags", 64'({zero, overflow, divByZero}), 64'({cur.z, cur.ovf, cur.dbz}));
        end
        prev_v = !outReady;
      end else begin
        prev_v = 1'b0;
      end
    end
  end

  initial begin : stim
    exp_t e;
    int n;
    int bad;
    rst_n = 1'b0; inValid = 1'b0; outReady = 1'b1; dataA = '0; dataB = '0; Signal = '0;
    v8_in = 1'b0; r8_out = 1'b1; a8 = '0; b8 = '0; s8 = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_outputs", 64'({outValid, zero, overflow, divByZero}), 64'd0);
    chk("reset_data", {dataOut, dataOutHi}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk("reset_inReady", 64'(inReady), 64'd1);

    // Directed corner cases
    issue(3'b010, 32'h7FFF_FFFF, 32'h1, 1'b0);
    issue(3'b110, 32'd5, 32'd5, 1'b0);
    issue(3'b111, 32'hFFFF_FFFF, 32'h1, 1'b0);
    issue(3'b111, 32'h1, 32'hFFFF_FFFF, 1'b0);
    issue(3'b000, 32'hF0F0_1234, 32'h0FF0_FFFF, 1'b0);
    issue(3'b001, 32'hF000_0000, 32'h0000_000F, 1'b0);
    issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    bad = 0;
    for (int i = 0; i < W; i++) begin
      @(negedge clk); #1;
      if (inReady) bad++;
    end
    chk("busy_inReady_low", 64'(bad), 64'd0);
    issue(3'b100, 32'd100, 32'd7, 1'b0);
    issue(3'b100, 32'd100, 32'd0, 1'b0);
    issue(3'b101, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
    issue(3'b110, 32'h8000_0000, 32'h1, 1'b0);
    drain();

    // Randomized traffic with random output backpressure
    for (int i = 0; i < 150; i++) begin
      issue(3'($urandom_range(0, 7)), rnd_operand(), rnd_operand(), 1'b1);
    end
    drain();

    // Backpressure: held result blocks a pending op until the consumer takes it
    outReady = 1'b0;
    issue(3'b010, 32'd10, 32'd20, 1'b0);
    n = 0;
    while (!outValid && n < 10) begin
      @(negedge clk); #1; n++;
    end
    chk("bp_result_present", 64'(outValid), 64'd1);
    inValid = 1'b1; Signal = 3'b001; dataA = 32'h00FF_0000; dataB = 32'h0000_00FF;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (inReady) bad++;
      @(negedge clk); #1;
    end
    chk("bp_inReady_low", 64'(bad), 64'd0);
    outReady = 1'b1;
    #1;
    chk("bp_accept_on_handshake", 64'(inReady), 64'd1);
    e = model(3'b001, 32'h00FF_0000, 32'h0000_00FF);
    e.arrive = cyc + 2;
    q.push_back(e);
    @(posedge clk); #1;
    inValid = 1'b0;
    drain();

    // Reset in the middle of a multiply aborts it with no result
    issue(3'b100, 32'h1234, 32'h0, 1'b0);
    drain();
    issue(3'b011, 32'd3, 32'd5, 1'b0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midop_reset_outputs", 64'({outValid, zero, overflow, divByZero}), 64'd0);
    chk("midop_reset_data", {dataOut, dataOutHi}, 64'd0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk("post_reset_inReady", 64'(inReady), 64'd1);
    repeat (40) @(negedge clk);
    issue(3'b010, 32'hFFFF_FFFF, 32'h1, 1'b0);
    drain();

    // Narrow instance: 8-bit multiply latency and product
    @(negedge clk);
    v8_in = 1'b1; s8 = 3'b011; a8 = 8'hFF; b8 = 8'hFF;
    #1;
    chk("w8_accept", 64'(r8_in), 64'd1);
    n = cyc + 1 + 9;
    @(posedge clk); #1;
    v8_in = 1'b0; a8 = 8'h00; b8 = 8'h00;
    begin
      int k = 0;
      @(negedge clk); #3;
      while (!v8_out && k < 30) begin
        @(negedge clk); #3; k++;
      end
    end
    chk("w8_latency", 64'(cyc), 64'(n));
    chk("w8_product", 64'({hi8, lo8}), 64'h0000_0000_0000_FE01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/param_multicycle_alu.md
Name: param_multicycle_alu

Overview:
- Parametrised, handshaked successor to the 32-bit single-cycle ALU in the datapath.
- Generalised to WIDTH bits.
- Keeps AND/OR/ADD/SUB/SLT, with a registered result.
- Adds iterative unsigned multiply and divide, overflow and divide-by-zero flags, and valid/ready flow control so the pipeline can stall on multi-cycle ops.

Parameters:
- WIDTH, 32, operand/result width in bits (>=4).
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; do not override).

Ports:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- inValid  input  1  operands and Signal presented this cycle.
- inReady  output  1  block accepts an operation this cycle.
- dataA  input  WIDTH  operand A.
- dataB  input  WIDTH  operand B.
- Signal  input  3  op: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT, 011 MULU, 100 DIVU, 101/others reserved.
- outValid  output  1  result registers hold a valid result.
- outReady  input  1  consumer takes the result this cycle.
- dataOut  output  WIDTH  result; product low half for MULU, quotient for DIVU.
- dataOutHi  output  WIDTH  product high half for MULU, remainder for DIVU, 0 otherwise.
- zero  output  1  dataOut == 0.
- overflow  output  1  signed overflow on ADD/SUB, else 0.
- divByZero  output  1  DIVU with dataB == 0.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, counter=0. outValid, dataOut, dataOutHi, zero, overflow, divByZero all 0. Internal accumulators cleared.
- Reset mid-operation aborts the op with no result.
- Acceptance: inReady = (state==IDLE) && (!outValid || outReady). An op is accepted when inValid && inReady. Operands and Signal are latched on acceptance.
- Result hold: the result stays stable until outValid && outReady. outValid drops the cycle after a handshake unless a new result lands in the same edge.
- States:
  - IDLE -> DONE for single-cycle ops, reserved ops and DIVU by zero.
  - IDLE -> BUSY for MULU and DIVU with nonzero B.
  - BUSY -> DONE when the counter reaches WIDTH.
  - DONE -> IDLE, the same edge the result registers load and outValid sets.
- Latency, counted from the accepting edge T:
  - Single-cycle ops: outValid at T+1.
  - MULU/DIVU (B≠0): outValid at T+WIDTH+1; exactly WIDTH BUSY cycles, one bit per cycle.
  - Back-to-back single-cycle ops with outReady held high sustain one result per 2 cycles (IDLE/DONE alternation).
- ADD: dataOut = (A+B) mod 2^WIDTH. overflow = A[msb]==B[msb] && sum[msb]!=A[msb].
- SUB: dataOut = (A-B) mod 2^WIDTH. overflow = A[msb]!=B[msb] && diff[msb]!=A[msb].
- SLT: signed two's-complement compare; dataOut = {0..., A<B}.
- AND/OR: bitwise.
- All non-MUL/DIV ops: dataOutHi=0, overflow=0 except ADD/SUB.
- MULU: shift-add, unsigned, full 2*WIDTH product = {dataOutHi, dataOut}.
- DIVU: restoring divide, unsigned. Quotient → dataOut, remainder → dataOutHi.
- DIVU by zero: single-cycle. dataOut = all ones, dataOutHi = A, divByZero = 1.
- Reserved opcodes: single-cycle, all result outputs 0, zero=1.
- zero is computed from the final dataOut only. Flags are registered with the result and valid only while outValid=1.
- inValid while inReady=0 is ignored; the upstream must hold it.
- dataA/dataB changes during BUSY have no effect.
- Counter never exceeds WIDTH; no wrap-around.

Test Plan:
- Reset: assert rst_n=0 mid-MULU, BUSY cycle 5 → all outputs 0 immediately, outValid=0. After release, inReady=1 next cycle.
- ADD overflow, WIDTH=32: A=0x7FFFFFFF, B=1 → dataOut=0x80000000, overflow=1, zero=0, outValid at T+1.
- SUB and SLT:
  - SUB A=5, B=5 → dataOut=0, zero=1.
  - SLT A=0xFFFFFFFF (-1), B=1 → dataOut=1.
  - SLT A=1, B=0xFFFFFFFF → dataOut=0.
- MULU: A=0xFFFFFFFF, B=0xFFFFFFFF → dataOutHi=0xFFFFFFFE, dataOut=0x00000001, outValid at exactly T+33, inReady=0 throughout BUSY.
- DIVU:
  - A=100, B=7 → dataOut=14, dataOutHi=2 at T+33.
  - A=100, B=0 → dataOut=0xFFFFFFFF, dataOutHi=100, divByZero=1 at T+1.
- Backpressure: hold outReady=0 after an ADD result.
  - The result stays stable and inReady=0 for 10 cycles while inValid=1.
  - Raising outReady → handshake, then the next op is accepted that same cycle.
  - Repeat with WIDTH=8: MULU 0xFF*0xFF → Hi=0xFE, Lo=0x01 at T+9.
